data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra access wait states (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  MEM-stage access request.
REQ-006 SHALL have port req_wr  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-009 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-010 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse for loads and stores.
REQ-013 SHALL have port resp_rdata  output  32  extended load data, valid with resp_valid.
REQ-014 SHALL have port resp_err  output  1  misaligned-access flag, valid with resp_valid.
REQ-015 SHALL have port stall  output  1  pipeline freeze request to upstream registers.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; WAIT skipped (IDLE -> RESP) when WAIT_CYCLES=0.
REQ-017 SHALL drive req_ready=1 only in IDLE; requests presented in WAIT or RESP are not accepted.
REQ-018 SHALL latch req_wr/addr/wdata/size/unsigned on acceptance; inputs need be stable only in that cycle.
REQ-019 SHALL stay in WAIT exactly WAIT_CYCLES cycles using a down-counter loaded on acceptance.
REQ-020 SHALL assert resp_valid for exactly one cycle in RESP, cycle N+1+WAIT_CYCLES for acceptance in cycle N.
REQ-021 SHALL drive stall = (IDLE && req_valid) || WAIT; stall low in RESP.
REQ-022 SHALL index words with addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap-around).
REQ-023 SHALL on store write only the addressed lanes at the RESP-entry edge: byte lane addr[1:0], half lanes addr[1]*2..+1, word all lanes.
REQ-024 SHALL on load select the addressed byte/half, extend per req_unsigned, and hold resp_rdata until the next response.
REQ-025 SHALL drive resp_rdata=0 for store responses.
REQ-026 SHALL define misaligned as half with addr[0]=1 or word with addr[1:0]!=0.
REQ-027 SHALL permit back-to-back requests at one per 2+WAIT_CYCLES cycles, with no request lost or duplicated.

Reset
REQ-028 SHALL on rst_n low immediately force IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, stall 0, req_ready 0 while low.
REQ-029 SHALL abort an in-flight request on reset so that no memory write occurs and no response is issued; memory contents are not reset.
REQ-030 SHALL raise req_ready in the first cycle after rst_n deasserts.

Configuration
REQ-031 SHALL with DMEM_MISALIGN_TRAP_EN defined complete misaligned requests with resp_err=1, resp_rdata=0, and memory unmodified, at normal latency.
REQ-032 SHALL without DMEM_MISALIGN_TRAP_EN force alignment (half ignores addr[0], word ignores addr[1:0]) and tie resp_err to 0.

Verification
REQ-033 SHALL cover: store word 0xDEADBEEF @0x10, then load word @0x10 -> resp_rdata 0xDEADBEEF at acceptance+3 (WAIT_CYCLES=2).
REQ-034 SHALL cover: store byte 0x80 @0x13, then load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word @0x10 -> 0x80ADBEEF.
REQ-035 SHALL cover: req_valid held high for 3 consecutive requests -> exactly 3 resp_valid pulses 4 cycles apart, stall low only in RESP cycles.
REQ-036 SHALL cover: load half @0x11 -> trap build gives resp_err 1 and rdata 0; non-trap build gives half @0x10, resp_err 0.
REQ-037 SHALL cover: rst_n low during WAIT of a store @0x20 -> no resp_valid, word @0x20 unchanged, req_ready 1 after release.
REQ-038 SHALL cover: store @DEPTH_WORDS*4 -> lands at word 0 (wrap).

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for a pipeline MEM stage: byte/half/word loads and stores with fixed wait states.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned accesses instead of silently aligning them.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          wr_q, uns_q;
  logic [31:0]   addr_q, wdata_q;
  logic [1:0]    size_q;
  logic          resp_valid_q;
  logic [31:0]   hold_q;

  logic          cur_wr;
  logic [31:0]   cur_addr, cur_wdata;
  logic [1:0]    cur_size;
  logic [AW-1:0] cur_idx;
  logic          accept, enter_resp, do_write;
  logic [3:0]    be;
  logic [31:0]   wbytes, rd_word, load_data;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          unused_addr_bits;

  // In IDLE the live request drives the datapath so a zero-wait access can complete on its acceptance edge.
  assign cur_wr    = (state == S_IDLE) ? req_wr    : wr_q;
  assign cur_addr  = (state == S_IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state == S_IDLE) ? req_wdata : wdata_q;
  assign cur_size  = (state == S_IDLE) ? req_size  : size_q;
  assign cur_idx   = cur_addr[AW+1:2];
  assign unused_addr_bits = ^cur_addr[31:AW+2];

  assign accept     = rst_n && (state == S_IDLE) && req_valid;
  assign enter_resp = (WAIT_CYCLES == 0) ? accept
                                         : (rst_n && (state == S_WAIT) && (cnt == 4'd1));

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
  logic resp_err_q;
  assign misaligned = ((cur_size == 2'b01) && cur_addr[0]) ||
                      (cur_size[1] && (cur_addr[1:0] != 2'b00));
  assign do_write   = enter_resp && cur_wr && !misaligned;
  assign resp_err   = resp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          resp_err_q <= 1'b0;
    else if (enter_resp) resp_err_q <= misaligned;
  end
`else
  assign do_write = enter_resp && cur_wr;
  assign resp_err = 1'b0;
`endif

  always_comb begin
    be     = 4'b1111;
    wbytes = cur_wdata;
    unique case (cur_size)
      2'b00: begin
        be     = 4'b0001 << cur_addr[1:0];
        wbytes = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be     = cur_addr[1] ? 4'b1100 : 4'b0011;
        wbytes = {2{cur_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // One RAM per byte lane gives byte-enable writes; the read is captured on the same edge the write lands.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] rd_q;
      always_ff @(posedge clk) begin
        if (do_write && be[gi]) lane_mem[cur_idx] <= wbytes[gi*8 +: 8];
        if (enter_resp)         rd_q <= lane_mem[cur_idx];
      end
      assign rd_word[gi*8 +: 8] = rd_q;
    end
  endgenerate

  always_comb begin
    unique case (addr_q[1:0])
      2'b00:   byte_sel = rd_word[7:0];
      2'b01:   byte_sel = rd_word[15:8];
      2'b10:   byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = '0;
    if (!wr_q) begin
      unique case (size_q)
        2'b00:   load_data = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        2'b01:   load_data = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        default: load_data = rd_word;
      endcase
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    if (misaligned) load_data = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      wr_q         <= 1'b0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= 2'b00;
      resp_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      resp_valid_q <= enter_resp;
      unique case (state)
        S_IDLE: if (req_valid) begin
          wr_q    <= req_wr;
          uns_q   <= req_unsigned;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          size_q  <= req_size;
          cnt     <= 4'(WAIT_CYCLES);
          state   <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        default: begin
          hold_q <= load_data;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = rst_n && (state == S_IDLE);
  assign stall      = rst_n && (((state == S_IDLE) && req_valid) || (state == S_WAIT));
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_valid_q ? load_data : hold_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: driver queues expected responses, a negedge monitor checks them.
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam int WAITC = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic        req_ready, resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          burst_base = -1000;
  logic [31:0] last_rdata = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pops one expectation; also checks the burst stall/valid pattern.
  always @(negedge clk) begin
    exp_t e;
    int   ph;
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got response rdata 0x%08h at cycle %0d, required none", resp_rdata, cyc);
      end else begin
        e = sb.pop_front();
        $display("[TB] resp cycle %0d rdata 0x%08h err %0b", cyc, resp_rdata, resp_err);
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
        check("resp_cycle", cyc, e.cyc);
        last_rdata = e.rdata;
      end
    end
    if (cyc >= burst_base && cyc <= burst_base + 11) begin
      ph = (cyc - burst_base) % 4;
      check("burst_stall", {31'b0, stall}, {31'b0, (ph != 3)});
      check("burst_valid", {31'b0, resp_valid}, {31'b0, (ph == 3)});
    end
  end

  // Called at posedge+1; drives one request in a ready cycle and returns one cycle after acceptance.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input logic keep,
                       input logic push, input logic mark,
                       input logic [31:0] exp_rdata, input logic exp_err);
    int waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (req_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL req_ready_timeout: got req_ready %b after 50 cycles, required 1", req_ready);
    end else begin
      req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
      req_size = size; req_unsigned = uns;
      if (mark) burst_base = cyc;
      if (push) sb.push_back('{rdata: exp_rdata, err: exp_err, cyc: cyc + 1 + WAITC});
      $display("[TB] req cycle %0d wr %0b addr 0x%08h wdata 0x%08h size %0d uns %0b",
               cyc, wr, addr, wdata, size, uns);
      @(posedge clk); #1;
      if (!keep) req_valid = 1'b0;
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                       input logic exp_err);
    issue(1'b1, addr, data, size, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, exp_err);
  endtask

  task automatic load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                      input logic [31:0] exp_rdata, input logic exp_err);
    issue(1'b0, addr, 32'h0, size, uns, 1'b0, 1'b1, 1'b0, exp_rdata, exp_err);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Word store then load, byte store into lane 3 with sign/zero extension.
    store(32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
    load (32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
    store(32'h13, 32'h00000080, 2'b00, 1'b0);
    load (32'h13, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
    load (32'h13, 2'b00, 1'b1, 32'h00000080, 1'b0);
    load (32'h10, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0);
    load (32'h12, 2'b01, 1'b0, 32'hFFFF80AD, 1'b0);

    // Back-to-back with req_valid held high across three requests.
    issue(1'b1, 32'h40, 32'h12345678, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
    issue(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 32'h12345678, 1'b0);
    issue(1'b0, 32'h42, 32'h0, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00001234, 1'b0);

    // Misaligned accesses.
    load (32'h11, 2'b01, 1'b0, TRAP ? 32'h0 : 32'hFFFFBEEF, TRAP);
    store(32'h30, 32'h01020304, 2'b10, 1'b0);
    store(32'h31, 32'hCAFEF00D, 2'b10, TRAP);
    load (32'h30, 2'b10, 1'b0, TRAP ? 32'h01020304 : 32'hCAFEF00D, 1'b0);

    // Reset during the wait states of a store aborts it.
    store(32'h20, 32'h11223344, 2'b10, 1'b0);
    load (32'h20, 2'b10, 1'b0, 32'h11223344, 1'b0);
    issue(1'b1, 32'h20, 32'h55AA55AA, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_req_ready", {31'b0, req_ready}, 32'd0);
    check("abort_resp_rdata", resp_rdata, 32'd0);
    check("abort_resp_err", {31'b0, resp_err}, 32'd0);
    req_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort_stall", {31'b0, stall}, 32'd0);
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_ready_after", {31'b0, req_ready}, 32'd1);
    load (32'h20, 2'b10, 1'b0, 32'h11223344, 1'b0);

    // Address wrap past the top of memory.
    store(DEPTH * 4, 32'hA5A5A5A5, 2'b10, 1'b0);
    load (32'h0, 2'b10, 1'b0, 32'hA5A5A5A5, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);
    check("rdata_hold", resp_rdata, last_rdata);
    check("idle_resp_valid", {31'b0, resp_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
